// File: rtl/mmio_bus.sv
// Memory-mapped bus fabric: RAM/IO/unmapped decode, port registers, sticky error, Run conditioning.
// Define MMIO_READBACK_EN to make region-01 reads return port register contents.
module mmio_bus #(
    parameter int AW        = 9,
    parameter int DW        = 9,
    parameter int RAM_AW    = 7,
    parameter int NPORTS    = 4,
    parameter int DB_CYCLES = 16
) (
    input  logic                 Clock,
    input  logic                 Resetn,
    input  logic                 RunIn,
    output logic                 Run,
    input  logic [AW-1:0]        ADDR,
    input  logic [DW-1:0]        DOUT,
    input  logic                 W,
    output logic [DW-1:0]        DIN,
    output logic [RAM_AW-1:0]    ram_addr,
    output logic [DW-1:0]        ram_data,
    output logic                 ram_wren,
    input  logic [DW-1:0]        ram_q,
    output logic [NPORTS*DW-1:0] ports,
    output logic                 bus_err
);

    logic [1:0] region;
    logic [2:0] idx;
    logic       idx_ok;
    logic       io_wr;
    logic       err_wr;

    assign region = ADDR[AW-1:AW-2];
    assign idx    = ADDR[2:0];
    assign idx_ok = {1'b0, idx} < 4'(NPORTS);
    assign io_wr  = W && (region == 2'b01) && idx_ok;
    assign err_wr = W && (region[1] || ((region == 2'b01) && !idx_ok));

    assign ram_addr = ADDR[RAM_AW-1:0];
    assign ram_data = DOUT;
    assign ram_wren = W && (region == 2'b00);

    logic [NPORTS-1:0][DW-1:0] port_q;

    assign ports = port_q;

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            port_q  <= '0;
            bus_err <= 1'b0;
        end else begin
            for (int i = 0; i < NPORTS; i++) begin
                if (io_wr && (idx == 3'(i))) port_q[i] <= DOUT;
            end
            if (err_wr) bus_err <= 1'b1;
        end
    end

    // Read data is registered to line up with the RAM's one-cycle latency.
    logic [1:0] sel_q;

`ifdef MMIO_READBACK_EN
    logic [DW-1:0] rb_d;
    logic [DW-1:0] rb_q;

    always_comb begin
        rb_d = '0;
        for (int i = 0; i < NPORTS; i++) begin
            if ((region == 2'b01) && (idx == 3'(i))) rb_d = port_q[i];
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            sel_q <= 2'b11;
            rb_q  <= '0;
        end else begin
            sel_q <= region;
            rb_q  <= rb_d;
        end
    end

    always_comb begin
        case (sel_q)
            2'b00:   DIN = ram_q;
            2'b01:   DIN = rb_q;
            default: DIN = '0;
        endcase
    end
`else
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) sel_q <= 2'b11;
        else         sel_q <= region;
    end

    assign DIN = (sel_q == 2'b00) ? ram_q : '0;
`endif

    logic s1;
    logic s2;

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= RunIn;
            s2 <= s1;
        end
    end

    generate
        if (DB_CYCLES == 0) begin : g_nodb
            always_ff @(posedge Clock or negedge Resetn) begin
                if (!Resetn) Run <= 1'b0;
                else         Run <= s2;
            end
        end else begin : g_db
            localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
            logic [CW-1:0] cnt;

            always_ff @(posedge Clock or negedge Resetn) begin
                if (!Resetn) begin
                    Run <= 1'b0;
                    cnt <= '0;
                end else if (s2 == Run) begin
                    cnt <= '0;
                end else if (cnt == CW'(DB_CYCLES - 1)) begin
                    Run <= s2;
                    cnt <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_mmio_bus.sv
// Scoreboard bench for mmio_bus: random bus traffic against an array model,
// plus directed error, reset-abort and Run debounce checks.
module tb_mmio_bus;

    logic        clk;
    logic        Resetn;
    logic        RunIn;
    logic        Run;
    logic [8:0]  ADDR;
    logic [8:0]  DOUT;
    logic        W;
    logic [8:0]  DIN;
    logic [6:0]  ram_addr;
    logic [8:0]  ram_data;
    logic        ram_wren;
    logic [8:0]  ram_q;
    logic [35:0] ports;
    logic        bus_err;

    mmio_bus dut (
        .Clock    (clk),
        .Resetn   (Resetn),
        .RunIn    (RunIn),
        .Run      (Run),
        .ADDR     (ADDR),
        .DOUT     (DOUT),
        .W        (W),
        .DIN      (DIN),
        .ram_addr (ram_addr),
        .ram_data (ram_data),
        .ram_wren (ram_wren),
        .ram_q    (ram_q),
        .ports    (ports),
        .bus_err  (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous RAM the fabric talks to.
    logic [8:0] mem [128];
    initial for (int i = 0; i < 128; i++) mem[i] = '0;
    always @(posedge clk) begin
        if (ram_wren) mem[ram_addr] <= ram_data;
        ram_q <= mem[ram_addr];
    end

    typedef struct {
        logic [8:0]  din;
        logic [35:0] ports;
        logic        err;
    } exp_t;

    exp_t exp_q[$];

    int checks = 0;
    int passed = 0;

    logic [8:0] ref_ram [128];
    logic [8:0] ref_port [4];
    logic       ref_err;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req)
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        else
            passed++;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("din", 64'(DIN), 64'(e.din));
            chk("ports", 64'(ports), 64'(e.ports));
            chk("bus_err", 64'(bus_err), 64'(e.err));
        end
    end

    // Issue one bus cycle; inputs set just after an edge, sampled at the next.
    task automatic op(input logic [8:0] a, input logic w, input logic [8:0] d);
        logic [1:0] rg;
        int         ix;
        exp_t       e;
        rg = a[8:7];
        ix = int'(a[2:0]);
        ADDR = a;
        W = w;
        DOUT = d;
        #1;
        chk("ram_wren", 64'(ram_wren), 64'(w && rg == 2'b00));
        e.din = '0;
        if (rg == 2'b00) e.din = ref_ram[a[6:0]];
`ifdef MMIO_READBACK_EN
        if (rg == 2'b01 && ix < 4) e.din = ref_port[ix];
`endif
        if (w) begin
            if (rg == 2'b00) ref_ram[a[6:0]] = d;
            else if (rg == 2'b01 && ix < 4) ref_port[ix] = d;
            else ref_err = 1'b1;
        end
        for (int i = 0; i < 4; i++) e.ports[i*9 +: 9] = ref_port[i];
        e.err = ref_err;
        @(posedge clk);
        exp_q.push_back(e);
        #1;
    endtask

    task automatic drain();
        W = 1'b0;
        @(negedge clk);
        #1;
        chk("drain", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic rand_ops(input int n, input bit allow_err);
        logic [8:0] a;
        for (int k = 0; k < n; k++) begin
            a = 9'($urandom);
            if (!allow_err) begin
                a[8] = 1'b0;
                if (a[7]) a[2] = 1'b0;
            end
            op(a, 1'($urandom), 9'($urandom));
        end
    endtask

    task automatic run_latency(input string name, input logic lvl);
        int n;
        @(posedge clk);
        #1;
        RunIn = lvl;
        n = 0;
        while (Run !== lvl && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk(name, 64'(n), 64'd18);
        repeat (12) @(posedge clk);
        #1;
        chk({name, "_hold"}, 64'(Run), 64'(lvl));
    endtask

    initial begin
        bit seen;
        for (int i = 0; i < 128; i++) ref_ram[i] = '0;
        for (int i = 0; i < 4; i++) ref_port[i] = '0;
        ref_err = 1'b0;
        Resetn = 1'b0;
        RunIn = 1'b0;
        ADDR = '0;
        DOUT = '0;
        W = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ports", 64'(ports), 64'd0);
        chk("rst_err", 64'(bus_err), 64'd0);
        chk("rst_run", 64'(Run), 64'd0);
        chk("rst_din", 64'(DIN), 64'd0);
        Resetn = 1'b1;
        @(posedge clk);
        #1;

        op(9'h080, 1'b1, 9'h1A5);
        op(9'h083, 1'b1, 9'h0F3);
        op(9'h012, 1'b1, 9'h055);
        op(9'h012, 1'b0, 9'h000);
        op(9'h080, 1'b0, 9'h000);
        op(9'h083, 1'b0, 9'h000);
        op(9'h081, 1'b1, 9'h111);
        op(9'h081, 1'b0, 9'h000);
        rand_ops(300, 1'b0);
        drain();

        op(9'h100, 1'b1, 9'h1FF);
        op(9'h085, 1'b1, 9'h0AA);
        op(9'h1C0, 1'b0, 9'h000);
        op(9'h087, 1'b0, 9'h000);
        rand_ops(200, 1'b1);
        drain();

        // Reset arriving mid-write must not leave a partial port update.
        ADDR = 9'h081;
        DOUT = 9'h1FF;
        W = 1'b1;
        #2;
        Resetn = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_ports", 64'(ports), 64'd0);
        chk("abort_err", 64'(bus_err), 64'd0);
        chk("abort_din", 64'(DIN), 64'd0);
        W = 1'b0;
        Resetn = 1'b1;
        for (int i = 0; i < 4; i++) ref_port[i] = '0;
        ref_err = 1'b0;
        @(posedge clk);
        #1;
        op(9'h081, 1'b0, 9'h000);
        op(9'h012, 1'b0, 9'h000);
        op(9'h080, 1'b1, 9'h0C3);
        op(9'h080, 1'b0, 9'h000);
        drain();

        @(posedge clk);
        #1;
        RunIn = 1'b1;
        seen = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1;
            seen |= Run;
        end
        RunIn = 1'b0;
        repeat (30) begin
            @(posedge clk);
            #1;
            seen |= Run;
        end
        chk("glitch", 64'(seen), 64'd0);
        run_latency("run_rise", 1'b1);
        run_latency("run_fall", 1'b0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/mmio_bus.md
# mmio_bus

Parametrised memory-mapped bus fabric between the 9-bit processor and its memory/peripherals. It generalises the fixed RAM-plus-LED decode into NPORTS writable output registers, registered read-back aligned to the synchronous RAM's one-cycle latency, and a sticky bus-error flag. It also conditions the raw Run switch through a 2-flop synchroniser and debouncer. It sits at the system top, with the processor on one side and the RAM, LEDs and displays on the other.

## Interface
Parameters:
- AW, 9, processor address width.
- DW, 9, data width.
- RAM_AW, 7, RAM address width; must be ≤ AW-2.
- NPORTS, 4, number of output port registers, 1..8.
- DB_CYCLES, 16, debounce length in clocks; 0 disables debouncing but keeps the synchroniser.

Ports:
- Clock  in  1  system clock; all state updates on rising edge.
- Resetn  in  1  asynchronous, active-low reset.
- RunIn  in  1  raw, asynchronous Run switch.
- Run  out  1  synchronised, debounced Run to the processor.
- ADDR  in  AW  processor address.
- DOUT  in  DW  processor write data.
- W  in  1  processor write strobe.
- DIN  out  DW  read data to the processor.
- ram_addr  out  RAM_AW  equals ADDR[RAM_AW-1:0].
- ram_data  out  DW  equals DOUT.
- ram_wren  out  1  RAM write enable.
- ram_q  in  DW  RAM read data, one cycle after address.
- ports  out  NPORTS*DW  port i occupies bits [i*DW +: DW].
- bus_err  out  1  sticky error flag.

## Operation
Region select is ADDR[AW-1:AW-2].
- Region 00 is RAM.
  - ram_wren = W & region==00 (combinational).
- Region 01 is IO.
  - idx = ADDR[2:0].
  - W with idx<NPORTS: port[idx] <= DOUT at the clock edge.
  - W with idx≥NPORTS: no write; bus_err <= 1.
- Regions 10 and 11 are unmapped.
  - W: no write; bus_err <= 1.
  - Reads return 0.
- Read path, at every edge:
  - sel_q <= region.
  - rb_q <= port[idx] if region==01 and idx<NPORTS, else 0.
  - DIN = ram_q if sel_q==00, rb_q if sel_q==01, else 0.
- Write then read of the same port: rb_q reflects the new value only if the read address is presented after the write edge. A same-cycle write and read returns the old value.
- bus_err clears only on reset.
- Run conditioning:
  - s1 <= RunIn; s2 <= s1.
  - While s2 != Run, the counter increments. When the counter reaches DB_CYCLES-1, Run <= s2 and the counter clears.
  - While s2 == Run, the counter is held at 0.
  - With DB_CYCLES=0, Run <= s2 directly.
- Reset values:
  - ports = 0, bus_err = 0, Run = 0.
  - s1 = s2 = 0, counter = 0.
  - sel_q = 11, so DIN = 0.
- Reset asserted mid-transfer aborts the transfer; no partial port update.

## Timing
- Port write: value appears on ports the cycle after the W edge (1-cycle latency).
- Read: DIN is valid exactly one cycle after ADDR is presented, for both RAM and IO. The processor's existing one-cycle wait covers both.
- bus_err rises at the edge that samples the offending W.
- Run latency: 2 cycles (synchroniser) + DB_CYCLES from a stable RunIn change to a Run change.
- A glitch shorter than DB_CYCLES cycles produces no Run change.

## Configuration
- MMIO_READBACK_EN.
  - Defined: region-01 reads return port contents as above.
  - Undefined: rb_q is constant 0 and the read-back mux is removed; port writes, error and Run logic are unchanged.

## Test plan
- Reset, then check outputs → ports=0, bus_err=0, Run=0, DIN=0.
- Write 0x1A5 to ADDR 0x080, then 0x0F3 to 0x083 (NPORTS=4) → port0=0x1A5 and port3=0x0F3 one cycle after their respective edges; ram_wren never asserted.
- Write 0x055 to RAM at 0x012, then read 0x012 → ram_wren=1 for one cycle; DIN=0x055 one cycle after the read address.
- Read 0x080 after the port0 write → DIN=0x1A5 one cycle later with MMIO_READBACK_EN; 0 without.
- Write to 0x100, then to 0x085 (NPORTS=4) → bus_err=1 after the first write and stays 1; no port changes; cleared only by Resetn=0.
- DB_CYCLES=16: 5-cycle RunIn pulse → Run stays 0. RunIn held high 30 cycles → Run=1 at cycle 18 after the rise.
